// File: rtl/puf_soc_sipo_if.sv
// Handshake and data bundle between puf_soc_sipo and its neighbours.
// The upstream PISO/consumer side is the master, the SIPO is the slave.
interface puf_soc_sipo_if #(
    parameter int FRAM_SIZE = 160,
    parameter int CNT_W     = $clog2(FRAM_SIZE + 1)
);
    logic                 i_rx_en;
    logic                 i_rx_mode;
    logic                 i_rx_valid;
    logic                 i_rx_data;
    logic                 o_rx_ready;
    logic [FRAM_SIZE-1:0] o_rx_data;
    logic                 o_rx_valid;
    logic                 i_rx_ready;
    logic                 o_rx_done;
    logic                 o_rx_err;
    logic [CNT_W-1:0]     o_rx_cnt;

    modport master (
        output i_rx_en, i_rx_mode, i_rx_valid, i_rx_data, i_rx_ready,
        input  o_rx_ready, o_rx_data, o_rx_valid, o_rx_done, o_rx_err, o_rx_cnt
    );

    modport slave (
        input  i_rx_en, i_rx_mode, i_rx_valid, i_rx_data, i_rx_ready,
        output o_rx_ready, o_rx_data, o_rx_valid, o_rx_done, o_rx_err, o_rx_cnt
    );
endinterface

// File: rtl/puf_soc_sipo.sv
// Serial-in parallel-out receiver: rebuilds an LSB-first normal or debug frame
// and offers it downstream under valid/ready, with abort and done pulses.
module puf_soc_sipo #(
    parameter int FRAM_SIZE = 160,
    parameter int NORM_MOD  = 34,
    parameter int DEBUG_MOD = 133,
    parameter int CNT_W     = $clog2(FRAM_SIZE + 1)
) (
    input  logic           clk,
    input  logic           rst,
    puf_soc_sipo_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic                 mode_r, mode_s;
    logic [FRAM_SIZE-1:0] data_r, data_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 ready_r, ready_s;
    logic                 valid_r, valid_s;
    logic                 done_r, done_s;
    logic                 err_r, err_s;
    logic [CNT_W-1:0]     last_idx_s;

    // Mode is latched at frame start, so the frame length cannot change mid-frame.
    assign last_idx_s = mode_r ? CNT_W'(DEBUG_MOD - 1) : CNT_W'(NORM_MOD - 1);

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            mode_r  <= 1'b0;
            data_r  <= {FRAM_SIZE{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ready_r <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            mode_r  <= mode_s;
            data_r  <= data_s;
            cnt_r   <= cnt_s;
            ready_r <= ready_s;
            valid_r <= valid_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        data_s  = data_r;
        cnt_s   = cnt_r;
        ready_s = 1'b0;
        valid_s = valid_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.i_rx_en) begin
                    mode_s  = bus.i_rx_mode;
                    data_s  = {FRAM_SIZE{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    ready_s = 1'b1;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                // Abort wins over a bit offered on the same cycle.
                if (!bus.i_rx_en) begin
                    data_s  = {FRAM_SIZE{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    valid_s = 1'b0;
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else if (bus.i_rx_valid && ready_r) begin
                    data_s[cnt_r] = bus.i_rx_data;
                    cnt_s         = cnt_r + CNT_W'(1);
                    if (cnt_r == last_idx_s) begin
                        valid_s = 1'b1;
                        state_s = HOLD;
                    end else begin
                        ready_s = 1'b1;
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end
            HOLD: begin
                if (valid_r && bus.i_rx_ready) begin
                    valid_s = 1'b0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                data_s  = {FRAM_SIZE{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    assign bus.o_rx_ready = ready_r;
    assign bus.o_rx_data  = data_r;
    assign bus.o_rx_valid = valid_r;
    assign bus.o_rx_done  = done_r;
    assign bus.o_rx_err   = err_r;
    assign bus.o_rx_cnt   = cnt_r;
endmodule

// File: tb/tb_puf_soc_sipo.sv
// Directed-plus-random bench for puf_soc_sipo: frames are built from random
// or fixed words and every expectation comes from the frame-length rules.
module tb_puf_soc_sipo;
    localparam int FS    = 160;
    localparam int CW    = 8;
    localparam int NNORM = 34;
    localparam int NDBG  = 133;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    puf_soc_sipo_if #(.FRAM_SIZE(FS), .CNT_W(CW)) bus ();

    puf_soc_sipo #(.FRAM_SIZE(FS), .NORM_MOD(NNORM), .DEBUG_MOD(NDBG), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [FS-1:0] obs, input logic [FS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FS-1:0] rand_word();
        logic [FS-1:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w;
    endfunction

    // Starts a frame at a negedge and feeds nsend bits; gaps of gN_len idle
    // cycles follow the bit with index gN_at. Returns the expected frame word.
    task automatic send_frame(input logic mode, input logic [FS-1:0] vec, input int nsend,
                              input bit toggle, input int g1_at, input int g1_len,
                              input int g2_at, input int g2_len, output logic [FS-1:0] exp);
        int n;
        n   = mode ? NDBG : NNORM;
        exp = '0;
        for (int i = 0; i < n; i++) exp[i] = vec[i];
        bus.i_rx_en    = 1'b1;
        bus.i_rx_mode  = mode;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 1'($urandom);
        @(negedge clk);
        check("start_ready", FS'(bus.o_rx_ready), FS'(1));
        check("start_cnt", FS'(bus.o_rx_cnt), FS'(0));
        check("start_data", bus.o_rx_data, '0);
        for (int i = 0; i < nsend; i++) begin
            bus.i_rx_valid = 1'b1;
            bus.i_rx_data  = vec[i];
            if (toggle) bus.i_rx_mode = 1'($urandom);
            @(negedge clk);
            check("bit_cnt", FS'(bus.o_rx_cnt), FS'(i + 1));
            if (i < n - 1) begin
                check("bit_ready", FS'(bus.o_rx_ready), FS'(1));
                check("bit_valid", FS'(bus.o_rx_valid), FS'(0));
            end else begin
                check("last_ready", FS'(bus.o_rx_ready), FS'(0));
                check("last_valid", FS'(bus.o_rx_valid), FS'(1));
                check("last_data", bus.o_rx_data, exp);
            end
            if (i == g1_at || i == g2_at) begin
                repeat ((i == g1_at) ? g1_len : g2_len) begin
                    bus.i_rx_valid = 1'b0;
                    bus.i_rx_data  = 1'($urandom);
                    @(negedge clk);
                    check("gap_cnt", FS'(bus.o_rx_cnt), FS'(i + 1));
                end
            end
        end
        bus.i_rx_valid = 1'b0;
    endtask

    // Holds the frame for hold cycles with noise on the serial side, then accepts it.
    task automatic finish_frame(input int hold, input logic [FS-1:0] exp, input int n);
        for (int k = 0; k < hold; k++) begin
            bus.i_rx_ready = 1'b0;
            bus.i_rx_valid = 1'($urandom);
            bus.i_rx_data  = 1'($urandom);
            bus.i_rx_en    = 1'($urandom);
            @(negedge clk);
            check("hold_valid", FS'(bus.o_rx_valid), FS'(1));
            check("hold_ready", FS'(bus.o_rx_ready), FS'(0));
            check("hold_data", bus.o_rx_data, exp);
            check("hold_cnt", FS'(bus.o_rx_cnt), FS'(n));
        end
        bus.i_rx_ready = 1'b1;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_en    = 1'b0;
        @(negedge clk);
        check("done_pulse", FS'(bus.o_rx_done), FS'(1));
        check("done_err", FS'(bus.o_rx_err), FS'(0));
        check("done_valid", FS'(bus.o_rx_valid), FS'(0));
        check("done_data_kept", bus.o_rx_data, exp);
        bus.i_rx_ready = 1'b0;
        @(negedge clk);
        check("done_once", FS'(bus.o_rx_done), FS'(0));
        check("idle_ready", FS'(bus.o_rx_ready), FS'(0));
    endtask

    initial begin
        logic [FS-1:0] vec;
        logic [FS-1:0] exp;
        checks = 0;
        errors = 0;
        rst            = 1'b1;
        bus.i_rx_en    = 1'b0;
        bus.i_rx_mode  = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 1'b0;
        bus.i_rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", FS'(bus.o_rx_ready), FS'(0));
        check("rst_valid", FS'(bus.o_rx_valid), FS'(0));
        check("rst_cnt", FS'(bus.o_rx_cnt), FS'(0));
        check("rst_data", bus.o_rx_data, '0);
        rst = 1'b0;
        @(negedge clk);

        // Normal frame with a continuous stream.
        vec = FS'(34'h2_A5A5_A5A5);
        send_frame(1'b0, vec, NNORM, 1'b0, -1, 0, -1, 0, exp);
        check("norm_word", bus.o_rx_data, FS'(34'h2_A5A5_A5A5));
        finish_frame(0, exp, NNORM);

        // Debug frame with random content and mode toggling mid-frame.
        vec = rand_word();
        send_frame(1'b1, vec, NDBG, 1'b1, -1, 0, -1, 0, exp);
        check("dbg_upper_zero", FS'(bus.o_rx_data[FS-1:NDBG]), '0);
        finish_frame(0, exp, NDBG);

        // Gapped stream.
        vec = FS'(34'h1_2345_6789);
        send_frame(1'b0, vec, NNORM, 1'b0, 12, 5, 20, 3, exp);
        finish_frame(0, exp, NNORM);

        // Output backpressure, then a random follow-up frame.
        vec = rand_word();
        send_frame(1'b0, vec, NNORM, 1'b0, -1, 0, -1, 0, exp);
        finish_frame(5, exp, NNORM);
        vec = rand_word();
        send_frame(1'b0, vec, NNORM, 1'b0, 7, 2, -1, 0, exp);
        finish_frame(1, exp, NNORM);

        // Abort after 10 bits, with a bit offered on the abort cycle.
        vec = rand_word();
        send_frame(1'b0, vec, 10, 1'b0, -1, 0, -1, 0, exp);
        bus.i_rx_en    = 1'b0;
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 1'b1;
        @(negedge clk);
        check("abort_err", FS'(bus.o_rx_err), FS'(1));
        check("abort_done", FS'(bus.o_rx_done), FS'(0));
        check("abort_valid", FS'(bus.o_rx_valid), FS'(0));
        check("abort_cnt", FS'(bus.o_rx_cnt), FS'(0));
        check("abort_data", bus.o_rx_data, '0);
        bus.i_rx_valid = 1'b0;
        @(negedge clk);
        check("abort_err_once", FS'(bus.o_rx_err), FS'(0));
        vec = rand_word();
        send_frame(1'b0, vec, NNORM, 1'b0, -1, 0, -1, 0, exp);
        finish_frame(2, exp, NNORM);

        // Asynchronous reset in the middle of a debug frame.
        vec = rand_word();
        send_frame(1'b1, vec, 70, 1'b0, -1, 0, -1, 0, exp);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", FS'(bus.o_rx_ready), FS'(0));
        check("arst_valid", FS'(bus.o_rx_valid), FS'(0));
        check("arst_cnt", FS'(bus.o_rx_cnt), FS'(0));
        check("arst_data", bus.o_rx_data, '0);
        check("arst_done", FS'(bus.o_rx_done), FS'(0));
        check("arst_err", FS'(bus.o_rx_err), FS'(0));
        bus.i_rx_en    = 1'b0;
        bus.i_rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", FS'(bus.o_rx_done), FS'(0));
        check("post_rst_err", FS'(bus.o_rx_err), FS'(0));
        vec = rand_word();
        send_frame(1'b0, vec, NNORM, 1'b0, -1, 0, -1, 0, exp);
        finish_frame(0, exp, NNORM);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/puf_soc_sipo.md
Name: puf_soc_sipo

Overview:
Serial-in parallel-out receive stage that sits directly downstream of puf_soc_piso. It consumes the PISO's LSB-first serial bit stream under a valid/ready handshake and reassembles either a 34-bit normal frame or a 133-bit debug frame into a FRAM_SIZE-wide word. The word is then presented to the downstream frame consumer with its own valid/ready handshake. The block provides bit-level backpressure, frame-abort detection and a one-cycle done pulse.

Parameters:
FRAM_SIZE, 160, width of the parallel output word.
NORM_MOD, 34, bits per normal-mode frame (must be <= FRAM_SIZE).
DEBUG_MOD, 133, bits per debug-mode frame (must be <= FRAM_SIZE).
CNT_W, $clog2(FRAM_SIZE+1), width of the bit counter.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
i_rx_en  in  1  1 enables frame reception; dropping it mid-frame aborts the frame.
i_rx_mode  in  1  0 = normal frame (NORM_MOD bits), 1 = debug frame (DEBUG_MOD bits); sampled at frame start.
i_rx_valid  in  1  serial bit on i_rx_data is valid (driven by PISO o_tx_valid).
i_rx_data  in  1  serial data bit, LSB first (driven by PISO o_tx_data).
o_rx_ready  out  1  block accepts a serial bit this cycle (feeds PISO i_tx_ready).
o_rx_data  out  FRAM_SIZE  assembled frame, zero-extended above the frame length.
o_rx_valid  out  1  o_rx_data holds a complete frame.
i_rx_ready  in  1  downstream consumer accepts the frame.
o_rx_done  out  1  one-cycle pulse after the frame handshake completes.
o_rx_err  out  1  one-cycle pulse when a frame is aborted.
o_rx_cnt  out  CNT_W  number of bits accepted in the current frame.

Behaviour:
- Reset (async, rst=1): state IDLE; o_rx_ready=0, o_rx_valid=0, o_rx_done=0, o_rx_err=0, o_rx_cnt=0, o_rx_data=0, latched mode=0.
- Frame length N = NORM_MOD if latched mode=0, else DEBUG_MOD.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - o_rx_ready=0.
  - If i_rx_en=1: latch i_rx_mode, clear o_rx_data and o_rx_cnt, go to SHIFT.
- SHIFT:
  - o_rx_ready=1, registered; it is high on the first SHIFT cycle.
  - A bit is accepted when i_rx_valid && o_rx_ready: o_rx_data[o_rx_cnt] <= i_rx_data, then o_rx_cnt++. The first received bit lands at index 0.
  - Cycles with i_rx_valid=0 are gaps: no change, no timeout.
  - Mode changes on i_rx_mode after frame start are ignored.
  - Acceptance of bit N-1 (o_rx_cnt==N-1) at edge t: after edge t, state=HOLD, o_rx_valid=1, o_rx_ready=0, o_rx_cnt=N.
  - If i_rx_en=0 in SHIFT: bits are not accepted; go to IDLE; o_rx_err pulses for 1 cycle; o_rx_data is cleared; o_rx_valid is never raised. This applies even if i_rx_valid=1 on the same cycle.
- HOLD:
  - o_rx_valid=1; o_rx_data and o_rx_cnt are stable; o_rx_ready=0, so the PISO stalls.
  - Bits above N-1 of o_rx_data read 0.
  - On o_rx_valid && i_rx_ready: go to IDLE, o_rx_valid=0, o_rx_done=1 for exactly the next cycle.
  - o_rx_data holds its value until the next frame start.
  - i_rx_en is ignored in HOLD; a completed frame is never aborted.
  - i_rx_ready may stay low indefinitely.
- Back-to-back frames: HOLD -> IDLE -> SHIFT. Minimum one IDLE cycle, so o_rx_ready is low for at least 2 cycles between frames.
- o_rx_done and o_rx_err are never high together.
- Reset asserted mid-frame or in HOLD: all outputs go to reset values immediately, with no done or err pulse.

Test Plan:
- Normal frame:
  - Stimulus: mode=0, en=1; PISO-style stream of 34'h2_A5A5_A5A5, LSB first, valid every cycle.
  - Required: o_rx_valid rises the cycle after bit 33; o_rx_data = 160'h2_A5A5_A5A5; o_rx_cnt = 34.
  - Then i_rx_ready=1: o_rx_done pulses once.
- Debug frame:
  - Stimulus: mode=1; 133-bit random value.
  - Required: o_rx_data[132:0] matches, [159:133] = 0, o_rx_cnt = 133.
  - Toggling i_rx_mode mid-frame has no effect.
- Gapped stream:
  - Stimulus: 34-bit frame 34'h1_2345_6789 with i_rx_valid low for 5 cycles after bit 12 and 3 cycles after bit 20.
  - Required: correct word; o_rx_cnt freezes during the gaps.
- Output backpressure:
  - Stimulus: i_rx_ready=0 for 5 cycles in HOLD.
  - Required: o_rx_valid and o_rx_data stable, o_rx_ready=0 throughout, i_rx_valid bits ignored.
  - On release: done pulse, then the next frame is received correctly.
- Abort:
  - Stimulus: en dropped after 10 bits of a normal frame.
  - Required: o_rx_err pulses 1 cycle, no o_rx_valid, o_rx_cnt=0.
  - A subsequent full frame receives correctly.
- Async reset:
  - Stimulus: rst pulsed mid-cycle at bit 70 of a debug frame.
  - Required: all outputs 0 immediately, with no done or err pulse.
  - After reset release, a normal frame passes.
